// File: rtl/spart_pkg.sv
// spart_pkg: shared bus address map, status bit positions and FSM state types
// for the SPART UART. The parity state exists only when SPART_PARITY_EN is defined.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;

  localparam int unsigned ST_RDA        = 0;
  localparam int unsigned ST_TBR        = 1;
  localparam int unsigned ST_TX_IDLE    = 2;
  localparam int unsigned ST_OVERRUN    = 3;
  localparam int unsigned ST_FRAME_ERR  = 4;
  localparam int unsigned ST_PARITY_ERR = 5;

`ifdef SPART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: show-ahead synchronous FIFO. Pointers carry one extra wrap bit.
// Push on a full FIFO is accepted only when a pop happens in the same cycle;
// pop on an empty FIFO is ignored.
module spart_fifo
  import spart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spart_uart.sv
// spart_uart: full-duplex UART on the processor I/O bus with TX/RX FIFOs,
// programmable baud divisor, 16x-style oversampled RX and sticky error flags.
// Optional feature macro: SPART_PARITY_EN (even parity bit after the data).
module spart_uart
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [15:0] DIV_RESET  = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  // Bus decode
  logic       rd_en, wr_en, stat_rd;
  logic [7:0] rd_data, status;
  assign rd_en   = iocs && iorw;
  assign wr_en   = iocs && !iorw;
  assign stat_rd = rd_en && (ioaddr == ADDR_STAT);
  assign databus = rd_en ? rd_data : 'z;

  // Baud generator
  logic [15:0] div_q, div_n, baud_cnt;
  logic        div_wr, tick;
  assign tick = (baud_cnt == '0);

  // Divisor byte writes; either byte write also reloads the counter.
  always_comb begin
    div_n  = div_q;
    div_wr = 1'b0;
    if (wr_en && ioaddr == ADDR_DIVL) begin
      div_n[7:0] = databus;
      div_wr     = 1'b1;
    end
    if (wr_en && ioaddr == ADDR_DIVH) begin
      div_n[15:8] = databus;
      div_wr      = 1'b1;
    end
  end

  // Divisor register and tick down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_RESET;
      baud_cnt <= DIV_RESET;
    end else begin
      div_q <= div_n;
      if (div_wr)    baud_cnt <= div_n;
      else if (tick) baud_cnt <= div_q;
      else           baud_cnt <= baud_cnt - 1'b1;
    end
  end

  // FIFOs
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head, rx_sh;

  assign tx_push = wr_en && (ioaddr == ADDR_DATA);
  assign rx_pop  = rd_en && (ioaddr == ADDR_DATA);

  spart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(databus[DATA_BITS-1:0]),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  spart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_sh),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  assign rda = !rx_empty;
  assign tbr = !tx_full;

  // Transmitter
  tx_state_t            tx_state, tx_state_n;
  logic [OSW-1:0]       tx_os, tx_os_n;
  logic [BW-1:0]        tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_idle;
`ifdef SPART_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif

  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  // TX next state. IDLE loads only on a tick so every bit, including the
  // start bit, lasts exactly OVERSAMPLE ticks.
  always_comb begin
    tx_state_n = tx_state;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
`ifdef SPART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    if (tx_state == TX_IDLE) begin
      if (tick && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_n    = tx_head;
        tx_os_n    = '0;
        tx_state_n = TX_START;
`ifdef SPART_PARITY_EN
        tx_par_n   = ^tx_head;
`endif
      end
    end else if (tick) begin
      if (tx_os != OS_LAST) begin
        tx_os_n = tx_os + 1'b1;
      end else begin
        tx_os_n = '0;
        case (tx_state)
          TX_START: begin
            tx_bit_n   = '0;
            tx_state_n = TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == BIT_LAST) begin
`ifdef SPART_PARITY_EN
              tx_state_n = TX_PARITY;
`else
              tx_state_n = TX_STOP;
`endif
            end else begin
              tx_bit_n = tx_bit + 1'b1;
              tx_sh_n  = tx_sh >> 1;
            end
          end
`ifdef SPART_PARITY_EN
          TX_PARITY: tx_state_n = TX_STOP;
`endif
          TX_STOP: begin
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_sh_n    = tx_head;
              tx_state_n = TX_START;
`ifdef SPART_PARITY_EN
              tx_par_n   = ^tx_head;
`endif
            end else begin
              tx_state_n = TX_IDLE;
            end
          end
          default: tx_state_n = TX_IDLE;
        endcase
      end
    end
  end

  // TX state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
`ifdef SPART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
`ifdef SPART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // Serial output from registered state only.
  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_sh[0];
`ifdef SPART_PARITY_EN
      TX_PARITY: txd = tx_par;
`endif
      default:   txd = 1'b1;
    endcase
  end

  // Receiver
  rx_state_t            rx_state, rx_state_n;
  logic [OSW-1:0]       rx_os, rx_os_n;
  logic [BW-1:0]        rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh_n;
  logic                 rxd_meta, rxd_s;
  logic                 frame_set, overrun_set, parity_set;
  logic                 frame_err, overrun, parity_err;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // RX next state: half-bit start check, then one sample per bit period.
  always_comb begin
    rx_state_n  = rx_state;
    rx_os_n     = rx_os;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_push     = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    parity_set  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxd_s) begin
          rx_os_n    = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_os == OS_HALF) begin
            rx_os_n    = '0;
            rx_bit_n   = '0;
            rx_state_n = rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_os_n = rx_os + 1'b1;
          end
        end
      end
      default: begin
        if (tick) begin
          if (rx_os != OS_LAST) begin
            rx_os_n = rx_os + 1'b1;
          end else begin
            rx_os_n = '0;
            case (rx_state)
              RX_DATA: begin
                rx_sh_n = {rxd_s, rx_sh[DATA_BITS-1:1]};
                if (rx_bit == BIT_LAST) begin
`ifdef SPART_PARITY_EN
                  rx_state_n = RX_PARITY;
`else
                  rx_state_n = RX_STOP;
`endif
                end else begin
                  rx_bit_n = rx_bit + 1'b1;
                end
              end
`ifdef SPART_PARITY_EN
              RX_PARITY: begin
                parity_set = (rxd_s != ^rx_sh);
                rx_state_n = RX_STOP;
              end
`endif
              RX_STOP: begin
                rx_state_n = RX_IDLE;
                if (!rxd_s) begin
                  frame_set = 1'b1;
                end else begin
                  rx_push     = 1'b1;
                  overrun_set = rx_full && !rx_pop;
                end
              end
              default: rx_state_n = RX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // RX state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_os    <= rx_os_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  // Sticky error flags; a set in the same cycle as a status read wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   || (frame_err && !stat_rd);
      overrun   <= overrun_set || (overrun && !stat_rd);
    end
  end

`ifdef SPART_PARITY_EN
  // Sticky parity flag.
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_set || (parity_err && !stat_rd);
  end
`else
  assign parity_err = 1'b0;
`endif

  // Status word and read-data mux.
  always_comb begin
    status                = '0;
    status[ST_RDA]        = rda;
    status[ST_TBR]        = tbr;
    status[ST_TX_IDLE]    = tx_idle;
    status[ST_OVERRUN]    = overrun;
    status[ST_FRAME_ERR]  = frame_err;
    status[ST_PARITY_ERR] = parity_err;
    rd_data               = '0;
    case (ioaddr)
      ADDR_DATA: if (!rx_empty) rd_data[DATA_BITS-1:0] = rx_head;
      ADDR_STAT: rd_data = status;
      ADDR_DIVL: rd_data = div_q[7:0];
      default:   rd_data = div_q[15:8];
    endcase
  end

endmodule
